// File: rtl/jtag_master_pkg.sv
// Shared constants and state encoding for the JTAG initiator.
package jtag_master_pkg;

    localparam int MAX_BITS  = 32;
    localparam int LEN_WIDTH = 5;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t LOW  = 2'd1;
    localparam state_t HIGH = 2'd2;
    localparam state_t RESP = 2'd3;

endpackage

// File: rtl/jtag_master_if.sv
// Command/response handshake bundle between a local controller and jtag_master.
interface jtag_master_if;
    import jtag_master_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic [MAX_BITS-1:0]  cmd_tms;
    logic [MAX_BITS-1:0]  cmd_tdi;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [MAX_BITS-1:0]  rsp_tdo;
    logic                 busy;

    // Controller side: issues commands, consumes capture words.
    modport master (
        output cmd_valid, cmd_len, cmd_tms, cmd_tdi, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tdo, busy
    );

    // Initiator side.
    modport slave (
        input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tdo, busy
    );

endinterface

// File: rtl/jtag_master_phase_gen.sv
// Half-period timer: pulses phase_end on the last main-clock cycle of each TCK phase.
module jtag_master_phase_gen #(
    parameter int CLK_DIV   = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic phase_end
);

    localparam logic [DIV_WIDTH-1:0] RELOAD = DIV_WIDTH'(CLK_DIV - 1);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign phase_end = run && (cnt_q == '0);

    // Count down from CLK_DIV-1; reload on a new command and at every phase boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (start || phase_end) begin
            cnt_d = RELOAD;
        end else if (run) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG initiator: shifts up to 32 TMS/TDI bits per command and returns captured TDO.
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic          io_mainClk,
    input  logic          io_asyncResetn,
    jtag_master_if.slave  bus,
    output logic          jtag_tck,
    output logic          jtag_tms,
    output logic          jtag_tdi,
    input  logic          jtag_tdo
);

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 tck_q, tck_d;
    logic                 tdo_q, tdo_d;
    logic [MAX_BITS-1:0]  tms_sh_q, tms_sh_d;
    logic [MAX_BITS-1:0]  tdi_sh_q, tdi_sh_d;
    logic [MAX_BITS-1:0]  cap_q, cap_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;
    logic                 accept;
    logic                 run;
    logic                 phase_end;

    // ready_q is only set while idle, so it alone qualifies acceptance.
    assign accept = ready_q && bus.cmd_valid;
    assign run    = (state_q == LOW) || (state_q == HIGH);

    jtag_master_phase_gen #(
        .CLK_DIV   (CLK_DIV),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_phase_gen (
        .clk       (io_mainClk),
        .rst_n     (io_asyncResetn),
        .start     (accept),
        .run       (run),
        .phase_end (phase_end)
    );

    // The current bit always sits in bit 0 of the shift registers; shifting stops
    // after the last bit so TMS/TDI hold their final level while idle.
    assign jtag_tck      = tck_q;
    assign jtag_tms      = tms_sh_q[0];
    assign jtag_tdi      = tdi_sh_q[0];
    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_tdo   = (state_q == RESP) ? cap_q : '0;
    assign bus.busy      = (state_q != IDLE);

    // Sequencer: accept, alternate LOW/HIGH phases per bit, present capture word.
    always_comb begin
        state_d  = state_q;
        tms_sh_d = tms_sh_q;
        tdi_sh_d = tdi_sh_q;
        cap_d    = cap_q;
        len_d    = len_q;
        idx_d    = idx_q;
        tdo_d    = jtag_tdo;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = LOW;
                    tms_sh_d = bus.cmd_tms;
                    tdi_sh_d = bus.cmd_tdi;
                    len_d    = bus.cmd_len;
                    idx_d    = '0;
                    cap_d    = '0;
                end
            end
            LOW: begin
                if (phase_end) state_d = HIGH;
            end
            HIGH: begin
                if (phase_end) begin
                    // TDO was launched by the target on the previous falling edge.
                    cap_d[idx_q] = tdo_q;
                    if (idx_q == len_q) begin
                        state_d = RESP;
                    end else begin
                        state_d  = LOW;
                        idx_d    = idx_q + 1'b1;
                        tms_sh_d = {1'b0, tms_sh_q[MAX_BITS-1:1]};
                        tdi_sh_d = {1'b0, tdi_sh_q[MAX_BITS-1:1]};
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // TCK and ready are registered from the next state so the pins are glitch-free.
        tck_d   = (state_d == HIGH);
        ready_d = (state_d == IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            tck_q    <= 1'b0;
            tdo_q    <= 1'b0;
            tms_sh_q <= MAX_BITS'(1);
            tdi_sh_q <= '0;
            cap_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            tck_q    <= tck_d;
            tdo_q    <= tdo_d;
            tms_sh_q <= tms_sh_d;
            tdi_sh_q <= tdi_sh_d;
            cap_q    <= cap_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench: CLK_DIV=4 instance for TAP-reset timing, CLK_DIV=2 loopback instance for the rest.
module tb_jtag_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic tck4, tms4, tdi4;
    logic tck2, tms2, tdi2;

    jtag_master_if if4 ();
    jtag_master_if if2 ();

    always #5 clk = ~clk;

    jtag_master #(.CLK_DIV(4), .DIV_WIDTH(16)) u_dut4 (
        .io_mainClk     (clk),
        .io_asyncResetn (rst_n),
        .bus            (if4.slave),
        .jtag_tck       (tck4),
        .jtag_tms       (tms4),
        .jtag_tdi       (tdi4),
        .jtag_tdo       (tdi4)
    );

    jtag_master #(.CLK_DIV(2), .DIV_WIDTH(16)) u_dut2 (
        .io_mainClk     (clk),
        .io_asyncResetn (rst_n),
        .bus            (if2.slave),
        .jtag_tck       (tck2),
        .jtag_tms       (tms2),
        .jtag_tdi       (tdi2),
        .jtag_tdo       (tdi2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with dut2 idle; returns right after the accepting posedge.
    task automatic send2(input logic [4:0] len, input logic [31:0] tms, input logic [31:0] tdi);
        check("send_ready", {63'd0, if2.cmd_ready}, 64'd1);
        if2.cmd_len   = len;
        if2.cmd_tms   = tms;
        if2.cmd_tdi   = tdi;
        if2.cmd_valid = 1'b1;
        @(posedge clk);
    endtask

    // Waits (bounded) for rsp_valid; k counts negedges from the first LOW cycle.
    task automatic wait_rsp2(output int cyc, output int rises, output bit ok);
        logic prev;
        prev  = 1'b0;
        rises = 0;
        cyc   = -1;
        ok    = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) if2.cmd_valid = 1'b0;
            if (tck2 && !prev) rises++;
            prev = tck2;
            if (if2.rsp_valid) begin
                cyc = k;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    // Called at a negedge with rsp_valid high; ends at the negedge after the handshake.
    task automatic handshake2();
        if2.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if2.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] obs_tck, exp_tck, obs_tms;
        logic [31:0] held;
        int cyc, rises, bad;
        bit ok;

        if4.cmd_valid = 1'b0; if4.cmd_len = '0; if4.cmd_tms = '0; if4.cmd_tdi = '0; if4.rsp_ready = 1'b0;
        if2.cmd_valid = 1'b0; if2.cmd_len = '0; if2.cmd_tms = '0; if2.cmd_tdi = '0; if2.rsp_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tck", {63'd0, tck4}, 64'd0);
        check("rst_tms", {63'd0, tms4}, 64'd1);
        check("rst_tdi", {63'd0, tdi4}, 64'd0);
        check("rst_cmd_ready", {63'd0, if4.cmd_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, if4.rsp_valid}, 64'd0);
        check("rst_busy", {63'd0, if4.busy}, 64'd0);
        check("rst_rsp_tdo", {32'd0, if4.rsp_tdo}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_edge", {63'd0, if4.cmd_ready}, 64'd0);
        @(negedge clk);
        check("rel_ready_after_edge", {63'd0, if4.cmd_ready}, 64'd1);

        // TAP reset sequence on CLK_DIV=4: 5 bits, TMS=1
        if4.cmd_len = 5'd4; if4.cmd_tms = 32'h1F; if4.cmd_tdi = 32'h0; if4.cmd_valid = 1'b1;
        @(posedge clk);
        obs_tck = '0; exp_tck = '0; obs_tms = '0; bad = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0) if4.cmd_valid = 1'b0;
            if (k < 40) begin
                obs_tck[k] = tck4;
                exp_tck[k] = ((k / 4) % 2) == 1;
                obs_tms[k] = tms4;
                if (if4.rsp_valid || if4.cmd_ready || !if4.busy) bad++;
            end
        end
        check("tap_tck_wave", obs_tck, exp_tck);
        check("tap_tms_wave", obs_tms, 64'h00FF_FFFF_FFFF);
        check("tap_no_early_rsp", 64'(bad), 64'd0);
        check("tap_rsp_at_40", {63'd0, if4.rsp_valid}, 64'd1);
        check("tap_rsp_tdo", {32'd0, if4.rsp_tdo}, 64'd0);
        check("tap_tck_low_resp", {63'd0, tck4}, 64'd0);
        if4.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.rsp_ready = 1'b0;
        check("tap_idle_tms_hold", {63'd0, tms4}, 64'd1);
        check("tap_idle_busy", {63'd0, if4.busy}, 64'd0);

        // Full 32-bit loopback on CLK_DIV=2
        send2(5'd31, 32'h0, 32'hA5C3_0F96);
        wait_rsp2(cyc, rises, ok);
        check("lb32_timeout", {63'd0, ok}, 64'd1);
        check("lb32_latency", 64'(cyc), 64'd128);
        check("lb32_rises", 64'(rises), 64'd32);
        check("lb32_rsp_tdo", {32'd0, if2.rsp_tdo}, 64'hA5C3_0F96);
        handshake2();
        check("lb32_rsp_clear", {63'd0, if2.rsp_valid}, 64'd0);

        // Partial length: 8 bits of ones
        send2(5'd7, 32'h0, 32'hFFFF_FFFF);
        wait_rsp2(cyc, rises, ok);
        check("lb8_timeout", {63'd0, ok}, 64'd1);
        check("lb8_latency", 64'(cyc), 64'd32);
        check("lb8_rises", 64'(rises), 64'd8);
        check("lb8_rsp_tdo", {32'd0, if2.rsp_tdo}, 64'h0000_00FF);
        handshake2();
        check("lb8_idle_tdi_hold", {63'd0, tdi2}, 64'd1);

        // Backpressure with a second command waiting
        send2(5'd3, 32'h0, 32'h0000_000A);
        wait_rsp2(cyc, rises, ok);
        check("bp_timeout", {63'd0, ok}, 64'd1);
        held = if2.rsp_tdo;
        check("bp_rsp_tdo", {32'd0, held}, 64'hA);
        if2.cmd_len = 5'd0; if2.cmd_tms = 32'h0; if2.cmd_tdi = 32'h1; if2.cmd_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (if2.rsp_tdo !== 32'hA || if2.cmd_ready || tck2 || !if2.rsp_valid) bad++;
        end
        check("bp_hold", 64'(bad), 64'd0);
        if2.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if2.rsp_ready = 1'b0;
        check("bp_ready_after_hs", {63'd0, if2.cmd_ready}, 64'd1);
        check("bp_rsp_drop", {63'd0, if2.rsp_valid}, 64'd0);
        check("bp_not_busy", {63'd0, if2.busy}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_second_accepted", {63'd0, if2.cmd_ready}, 64'd0);
        check("bp_second_busy", {63'd0, if2.busy}, 64'd1);
        wait_rsp2(cyc, rises, ok);
        check("bp2_timeout", {63'd0, ok}, 64'd1);
        check("bp2_rises", 64'(rises), 64'd1);
        check("bp2_rsp_tdo", {32'd0, if2.rsp_tdo}, 64'h1);
        handshake2();

        // Reset during bit 10 of a 32-bit command
        send2(5'd31, 32'h0, 32'hFFFF_FFFF);
        for (int k = 0; k <= 42; k++) begin
            @(negedge clk);
            if (k == 0) if2.cmd_valid = 1'b0;
        end
        check("mid_tck_high_bit10", {63'd0, tck2}, 64'd1);
        check("mid_tms_before", {63'd0, tms2}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tck", {63'd0, tck2}, 64'd0);
        check("mid_rst_tms", {63'd0, tms2}, 64'd1);
        check("mid_rst_tdi", {63'd0, tdi2}, 64'd0);
        check("mid_rst_ready", {63'd0, if2.cmd_ready}, 64'd0);
        check("mid_rst_busy", {63'd0, if2.busy}, 64'd0);
        check("mid_rst_rsp_tdo", {32'd0, if2.rsp_tdo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if2.rsp_valid || if2.busy || tck2) bad++;
        end
        check("mid_no_rsp", 64'(bad), 64'd0);
        send2(5'd4, 32'h0, 32'h13);
        wait_rsp2(cyc, rises, ok);
        check("post_timeout", {63'd0, ok}, 64'd1);
        check("post_latency", 64'(cyc), 64'd20);
        check("post_rsp_tdo", {32'd0, if2.rsp_tdo}, 64'h13);
        handshake2();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
